cavlc_nc_ram_2p: RTL and testbench
==================================

CAVLC_NC_RAM_2P -- requirements
Module: cavlc_nc_ram_2p

Interface
REQ-001 SHALL have parameter DATA_W, default 36: word width in bits.
REQ-002 SHALL have parameter ADDR_W, default 7: address width in bits.
REQ-003 SHALL have parameter DEPTH, default 120: number of valid words, 2 <= DEPTH <= 2^ADDR_W.
REQ-004 SHALL have port clk, input, 1: single clock, rising edge.
REQ-005 SHALL have port rst, input, 1: asynchronous, active-high reset.
REQ-006 SHALL have port clr_start, input, 1: one-cycle pulse that starts the zero-fill sweep.
REQ-007 SHALL have port busy, output, 1: high while the sweep runs.
REQ-008 SHALL have port clr_done, output, 1: one-cycle pulse in the cycle after the last sweep write.
REQ-009 SHALL have port we, input, 1: write enable, active high.
REQ-010 SHALL have port waddr, input, ADDR_W: write address.
REQ-011 SHALL have port wdata, input, DATA_W: write data.
REQ-012 SHALL have port rd, input, 1: read enable, active high.
REQ-013 SHALL have port raddr, input, ADDR_W: read address.
REQ-014 SHALL have port rdata, output, DATA_W: registered read data.
REQ-015 SHALL have port rvalid, output, 1: rdata is updated this cycle.
REQ-016 SHALL have port addr_err, output, 1: one-cycle pulse for an out-of-range access.

Function
REQ-017 SHALL implement a simple dual-port array of DEPTH words: one write port and one read port, both on clk.
REQ-018 Read SHALL have a latency of 1 cycle: rd=1 at edge N gives rdata and rvalid=1 at edge N+1.
REQ-019 With rd=0, rvalid SHALL be 0 and rdata SHALL hold its last value.
REQ-020 A write with we=1 and waddr<DEPTH SHALL update the array at that edge.
REQ-021 A write with waddr>=DEPTH SHALL be discarded and SHALL raise addr_err for the next cycle.
REQ-022 A read with raddr>=DEPTH SHALL return rdata=0 with rvalid=1 and SHALL raise addr_err for the next cycle.
REQ-023 The sweep state machine SHALL have states IDLE and CLEAR.
- IDLE->CLEAR on clr_start; the counter loads 0.
- In CLEAR the block writes 0 to address cnt, then cnt+1, one word per cycle.
- CLEAR->IDLE after writing DEPTH-1; clr_done pulses in the next cycle.
REQ-024 busy SHALL equal (state==CLEAR).
REQ-025 In CLEAR, user writes SHALL be ignored without setting addr_err.
REQ-026 In CLEAR, user reads SHALL complete with rdata=0 and rvalid=1.
REQ-027 A clr_start pulse during CLEAR SHALL restart the counter at 0, and SHALL NOT produce clr_done for the aborted sweep.
REQ-028 A full sweep SHALL take exactly DEPTH cycles from the first sweep write to the last.
REQ-029 A read and a write to the same in-range address in the same cycle SHALL follow REQ-040 and REQ-041.

Reset
REQ-030 On rst=1, state SHALL be IDLE and cnt SHALL be 0 asynchronously.
REQ-031 On rst=1, busy, clr_done, rvalid and addr_err SHALL be 0 and rdata SHALL be 0.
REQ-032 Reset SHALL NOT initialise array contents; contents are undefined until a sweep or explicit writes.
REQ-033 Reset asserted mid-sweep SHALL abort the sweep with no clr_done; already cleared words stay 0.
REQ-034 The first operation after reset deasserts SHALL be accepted at the first clk edge.

Configuration
REQ-035 Macro CAVLC_RAM_BYPASS_EN SHALL select the read-during-write behaviour.
REQ-036 When CAVLC_RAM_BYPASS_EN is defined, a same-address same-cycle read SHALL return the new wdata (write-first).
REQ-037 When CAVLC_RAM_BYPASS_EN is undefined, a same-address same-cycle read SHALL return the pre-write contents (read-first).
REQ-038 Port list and latency SHALL be identical in both builds.
REQ-039 Bypass SHALL apply only to user writes, never to sweep writes; reads during CLEAR always return 0.
REQ-040 Read-during-write at the same address SHALL follow REQ-036 in builds with the macro defined.
REQ-041 Read-during-write at the same address SHALL follow REQ-037 in builds without the macro.

Verification
REQ-042 Default parameters: write 0x123456789 to address 5, then rd address 5 in the next cycle -> one cycle later rdata=0x123456789 and rvalid=1.
REQ-043 Array holds 0xAAAA at address 10; assert we and rd to address 10 in the same cycle with wdata=0xBBBB -> rdata=0xBBBB with the macro defined, 0xAAAA without it.
REQ-044 clr_start with DEPTH=120 -> busy high for 120 cycles, clr_done pulses once, then reads of addresses 0, 60 and 119 return 0.
REQ-045 Write to address 120, then read address 127 -> array unchanged, rdata=0, addr_err pulses once for each access.
REQ-046 clr_start, then a second clr_start at sweep cycle 50 -> busy lasts 50+120 cycles with a single clr_done.
REQ-047 clr_start, then rst at sweep cycle 30 -> busy=0 immediately, no clr_done, addresses 0..29 read 0.

Source files
------------

// File: rtl/cavlc_nc_ram_2p.sv
// Simple dual-port word RAM with a background zero-fill sweep and range checking.
// Define CAVLC_RAM_BYPASS_EN for write-first reads; the default build is read-first.
module cavlc_nc_ram_2p #(
  parameter int DATA_W = 36,
  parameter int ADDR_W = 7,
  parameter int DEPTH  = 120
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              clr_start,
  output logic              busy,
  output logic              clr_done,
  input  logic              we,
  input  logic [ADDR_W-1:0] waddr,
  input  logic [DATA_W-1:0] wdata,
  input  logic              rd,
  input  logic [ADDR_W-1:0] raddr,
  output logic [DATA_W-1:0] rdata,
  output logic              rvalid,
  output logic              addr_err
);

  typedef enum logic {
    IDLE  = 1'b0,
    CLEAR = 1'b1
  } state_e;

  localparam logic [ADDR_W:0]   DepthExt = (ADDR_W+1)'(DEPTH);
  localparam logic [ADDR_W-1:0] LastAddr = ADDR_W'(DEPTH - 1);

  state_e            state_q, state_d;
  logic [ADDR_W-1:0] cnt_q, cnt_d;
  logic              clr_done_q, clr_done_d;
  logic [DATA_W-1:0] rdata_q, rdata_d;
  logic              rvalid_q, rvalid_d;
  logic              addr_err_q, addr_err_d;

  logic [DATA_W-1:0] mem [DEPTH];

  logic              clearing;
  logic              waddr_ok;
  logic              raddr_ok;
  logic              user_we;
  logic              mem_we;
  logic [ADDR_W-1:0] mem_waddr;
  logic [DATA_W-1:0] mem_wdata;

  assign clearing = (state_q == CLEAR);
  assign waddr_ok = ({1'b0, waddr} < DepthExt);
  assign raddr_ok = ({1'b0, raddr} < DepthExt);

  // The sweep owns the write port while it runs; user writes are dropped silently.
  assign user_we   = we && waddr_ok && !clearing;
  assign mem_we    = clearing || user_we;
  assign mem_waddr = clearing ? cnt_q : waddr;
  assign mem_wdata = clearing ? '0 : wdata;

  always_ff @(posedge clk) begin
    if (mem_we) begin
      mem[mem_waddr] <= mem_wdata;
    end
  end

  always_comb begin
    state_d    = state_q;
    cnt_d      = cnt_q;
    clr_done_d = 1'b0;
    case (state_q)
      IDLE: begin
        if (clr_start) begin
          state_d = CLEAR;
          cnt_d   = '0;
        end
      end
      CLEAR: begin
        if (clr_start) begin
          cnt_d = '0;
        end else if (cnt_q == LastAddr) begin
          state_d    = IDLE;
          cnt_d      = '0;
          clr_done_d = 1'b1;
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end
      default: begin
        state_d = IDLE;
        cnt_d   = '0;
      end
    endcase
  end

  // Reads during the sweep return zero so stale contents never leak out.
  always_comb begin
    rdata_d  = rdata_q;
    rvalid_d = 1'b0;
    if (rd) begin
      rvalid_d = 1'b1;
      if (clearing || !raddr_ok) begin
        rdata_d = '0;
`ifdef CAVLC_RAM_BYPASS_EN
      end else if (user_we && (waddr == raddr)) begin
        rdata_d = wdata;
`endif
      end else begin
        rdata_d = mem[raddr];
      end
    end
  end

  assign addr_err_d = (we && !waddr_ok && !clearing) || (rd && !raddr_ok);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q    <= IDLE;
      cnt_q      <= '0;
      clr_done_q <= 1'b0;
      rdata_q    <= '0;
      rvalid_q   <= 1'b0;
      addr_err_q <= 1'b0;
    end else begin
      state_q    <= state_d;
      cnt_q      <= cnt_d;
      clr_done_q <= clr_done_d;
      rdata_q    <= rdata_d;
      rvalid_q   <= rvalid_d;
      addr_err_q <= addr_err_d;
    end
  end

  assign busy     = clearing;
  assign clr_done = clr_done_q;
  assign rdata    = rdata_q;
  assign rvalid   = rvalid_q;
  assign addr_err = addr_err_q;

endmodule

// File: tb/tb_cavlc_nc_ram_2p.sv
// Directed self-checking bench for cavlc_nc_ram_2p at default parameters.
// Expectations for same-address read/write follow CAVLC_RAM_BYPASS_EN.
module tb_cavlc_nc_ram_2p;

  logic        clk;
  logic        rst;
  logic        clr_start;
  logic        busy;
  logic        clr_done;
  logic        we;
  logic [6:0]  waddr;
  logic [35:0] wdata;
  logic        rd;
  logic [6:0]  raddr;
  logic [35:0] rdata;
  logic        rvalid;
  logic        addr_err;

  int checks   = 0;
  int failures = 0;
  int busyCount = 0;
  int doneCount = 0;

  cavlc_nc_ram_2p dut (
    .clk       (clk),
    .rst       (rst),
    .clr_start (clr_start),
    .busy      (busy),
    .clr_done  (clr_done),
    .we        (we),
    .waddr     (waddr),
    .wdata     (wdata),
    .rd        (rd),
    .raddr     (raddr),
    .rdata     (rdata),
    .rvalid    (rvalid),
    .addr_err  (addr_err)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  // Busy cycles and clr_done pulses are tallied on the falling edge.
  always @(negedge clk) begin
    if (busy) busyCount++;
    if (clr_done) doneCount++;
  end

  task automatic checkOutput(input string tag, input logic [63:0] actual, input logic [63:0] expected);
    checks++;
    if (actual !== expected) begin
      failures++;
      $display("[TB] FAIL %s: got 0x%0h expected 0x%0h", tag, actual, expected);
    end
  endtask

  task automatic applyStimulus(input logic iWe, input logic [6:0] iWaddr, input logic [35:0] iWdata,
                               input logic iRd, input logic [6:0] iRaddr, input logic iClr);
    we        = iWe;
    waddr     = iWaddr;
    wdata     = iWdata;
    rd        = iRd;
    raddr     = iRaddr;
    clr_start = iClr;
    @(posedge clk);
    #1;
    we        = 1'b0;
    rd        = 1'b0;
    clr_start = 1'b0;
  endtask

  task automatic idleCycle();
    applyStimulus(1'b0, 7'd0, 36'd0, 1'b0, 7'd0, 1'b0);
  endtask

  task automatic writeWord(input logic [6:0] a, input logic [35:0] d);
    applyStimulus(1'b1, a, d, 1'b0, 7'd0, 1'b0);
  endtask

  task automatic readExpect(input string tag, input logic [6:0] a, input logic [35:0] exp);
    applyStimulus(1'b0, 7'd0, 36'd0, 1'b1, a, 1'b0);
    checkOutput(tag, 64'(rdata), 64'(exp));
    checkOutput({tag, "_rvalid"}, 64'(rvalid), 64'd1);
  endtask

  initial begin
    logic [35:0] rdwExp;
    int n;
    rst = 1'b0; clr_start = 1'b0; we = 1'b0; rd = 1'b0;
    waddr = '0; raddr = '0; wdata = '0;

    #2 rst = 1'b1;
    @(posedge clk); @(posedge clk); #1;
    checkOutput("rst_busy", 64'(busy), 64'd0);
    checkOutput("rst_clr_done", 64'(clr_done), 64'd0);
    checkOutput("rst_rvalid", 64'(rvalid), 64'd0);
    checkOutput("rst_addr_err", 64'(addr_err), 64'd0);
    checkOutput("rst_rdata", 64'(rdata), 64'd0);
    rst = 1'b0;

    // Basic write then read, and hold behaviour with rd low.
    writeWord(7'd5, 36'h123456789);
    readExpect("rd5", 7'd5, 36'h123456789);
    checkOutput("rd5_addr_err", 64'(addr_err), 64'd0);
    idleCycle();
    checkOutput("hold_rvalid", 64'(rvalid), 64'd0);
    checkOutput("hold_rdata", 64'(rdata), 64'h123456789);

    // Same-address read during write.
    writeWord(7'd10, 36'hAAAA);
`ifdef CAVLC_RAM_BYPASS_EN
    rdwExp = 36'hBBBB;
`else
    rdwExp = 36'hAAAA;
`endif
    applyStimulus(1'b1, 7'd10, 36'hBBBB, 1'b1, 7'd10, 1'b0);
    checkOutput("rdw_rdata", 64'(rdata), 64'(rdwExp));
    readExpect("rdw_after", 7'd10, 36'hBBBB);

    // Out-of-range write and read, each flagging its own pulse.
    writeWord(7'd120, 36'hDEAD);
    checkOutput("oor_wr_err", 64'(addr_err), 64'd1);
    idleCycle();
    checkOutput("oor_wr_err_clear", 64'(addr_err), 64'd0);
    readExpect("oor_rd", 7'd127, 36'd0);
    checkOutput("oor_rd_err", 64'(addr_err), 64'd1);
    idleCycle();
    checkOutput("oor_rd_err_clear", 64'(addr_err), 64'd0);
    readExpect("oor_keep5", 7'd5, 36'h123456789);
    readExpect("oor_keep10", 7'd10, 36'hBBBB);

    // Full sweep with a user access in the middle.
    writeWord(7'd60, 36'h5A5A5);
    busyCount = 0; doneCount = 0;
    applyStimulus(1'b0, 7'd0, 36'd0, 1'b0, 7'd0, 1'b1);
    checkOutput("sweep_busy_start", 64'(busy), 64'd1);
    n = 0;
    while (busy && n < 400) begin
      n++;
      if (n == 10) begin
        applyStimulus(1'b1, 7'd3, 36'hFFFF, 1'b1, 7'd5, 1'b0);
        checkOutput("sweep_rd_rdata", 64'(rdata), 64'd0);
        checkOutput("sweep_rd_rvalid", 64'(rvalid), 64'd1);
        checkOutput("sweep_wr_err", 64'(addr_err), 64'd0);
      end else begin
        idleCycle();
      end
    end
    checkOutput("sweep_done_now", 64'(clr_done), 64'd1);
    idleCycle(); idleCycle(); idleCycle();
    checkOutput("sweep_busy_cycles", 64'(busyCount), 64'd120);
    checkOutput("sweep_done_count", 64'(doneCount), 64'd1);
    readExpect("sweep_a0", 7'd0, 36'd0);
    readExpect("sweep_a60", 7'd60, 36'd0);
    readExpect("sweep_a119", 7'd119, 36'd0);
    readExpect("sweep_a3", 7'd3, 36'd0);

    // Restart mid-sweep.
    busyCount = 0; doneCount = 0;
    applyStimulus(1'b0, 7'd0, 36'd0, 1'b0, 7'd0, 1'b1);
    n = 0;
    while (busy && n < 400) begin
      n++;
      applyStimulus(1'b0, 7'd0, 36'd0, 1'b0, 7'd0, (n == 50));
    end
    idleCycle(); idleCycle(); idleCycle();
    checkOutput("restart_busy_cycles", 64'(busyCount), 64'd170);
    checkOutput("restart_done_count", 64'(doneCount), 64'd1);

    // Reset in the middle of a sweep.
    for (int i = 0; i < 40; i++) writeWord(7'(i), 36'h77);
    busyCount = 0; doneCount = 0;
    applyStimulus(1'b0, 7'd0, 36'd0, 1'b0, 7'd0, 1'b1);
    for (int i = 0; i < 30; i++) idleCycle();
    rst = 1'b1;
    #1;
    checkOutput("midrst_busy", 64'(busy), 64'd0);
    checkOutput("midrst_clr_done", 64'(clr_done), 64'd0);
    @(posedge clk); @(posedge clk); #1;
    rst = 1'b0;
    readExpect("midrst_a0", 7'd0, 36'd0);
    readExpect("midrst_a15", 7'd15, 36'd0);
    readExpect("midrst_a29", 7'd29, 36'd0);
    readExpect("midrst_a30", 7'd30, 36'h77);
    readExpect("midrst_a39", 7'd39, 36'h77);
    for (int i = 0; i < 130; i++) idleCycle();
    checkOutput("midrst_done_count", 64'(doneCount), 64'd0);
    checkOutput("midrst_busy_end", 64'(busy), 64'd0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
